// File: rtl/chip8_exec_unit.sv
// Multi-cycle Chip-8 ALU/skip/I-register execution unit with a V register file.
// One instruction in flight: IDLE -> DECODE -> EXEC -> (FLAG) -> DONE.
module chip8_exec_unit #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int I_W      = 16
) (
  input  logic                        cpu_clk,
  input  logic                        cpu_rst_n,
  input  logic [15:0]                 instr,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  output logic                        done,
  output logic                        skip,
  output logic                        illegal,
  output logic [I_W-1:0]              i_reg,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_FLAG   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_r;
  logic [15:0]       instr_r;
  logic [DATA_W-1:0] vx_r;
  logic [DATA_W-1:0] vy_r;
  logic              flag_r;
  logic              ready_r;
  logic              done_r;
  logic              skip_r;
  logic              illegal_r;
  logic [I_W-1:0]    i_r;
  logic [DATA_W-1:0] v_r [NUM_REGS];

  logic [AW-1:0]     x_s;
  logic [AW-1:0]     y_s;
  logic [DATA_W-1:0] kk_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] res_s;
  logic              flag_s;
  logic              wr_vx_s;
  logic              flag_op_s;
  logic              wr_i_s;
  logic [I_W-1:0]    i_next_s;
  logic              skip_s;
  logic              illegal_s;

  assign instr_ready = ready_r;
  assign done        = done_r;
  assign skip        = skip_r;
  assign illegal     = illegal_r;
  assign i_reg       = i_r;
  assign dbg_data    = v_r[dbg_addr];

  // Decode the latched opcode against the latched operands.
  always_comb begin
    x_s       = AW'(instr_r[11:8]);
    y_s       = AW'(instr_r[7:4]);
    kk_s      = DATA_W'(instr_r[7:0]);
    sum_s     = {1'b0, vx_r} + {1'b0, vy_r};
    res_s     = vx_r;
    flag_s    = 1'b0;
    wr_vx_s   = 1'b0;
    flag_op_s = 1'b0;
    wr_i_s    = 1'b0;
    i_next_s  = i_r;
    skip_s    = 1'b0;
    illegal_s = 1'b0;
    case (instr_r[15:12])
      4'h3: skip_s = (vx_r == kk_s);
      4'h4: skip_s = (vx_r != kk_s);
      4'h5: begin
        if (instr_r[3:0] == 4'h0) begin
          skip_s = (vx_r == vy_r);
        end else begin
          illegal_s = 1'b1;
        end
      end
      4'h6: begin
        wr_vx_s = 1'b1;
        res_s   = kk_s;
      end
      4'h7: begin
        wr_vx_s = 1'b1;
        res_s   = vx_r + kk_s;
      end
      4'h8: begin
        wr_vx_s = 1'b1;
        case (instr_r[3:0])
          4'h0: res_s = vy_r;
          4'h1: res_s = vx_r | vy_r;
          4'h2: res_s = vx_r & vy_r;
          4'h3: res_s = vx_r ^ vy_r;
          4'h4: begin
            flag_op_s = 1'b1;
            res_s     = sum_s[DATA_W-1:0];
            flag_s    = sum_s[DATA_W];
          end
          4'h5: begin
            flag_op_s = 1'b1;
            res_s     = vx_r - vy_r;
            flag_s    = (vx_r >= vy_r);
          end
          4'h6: begin
            flag_op_s = 1'b1;
            res_s     = vx_r >> 1;
            flag_s    = vx_r[0];
          end
          4'h7: begin
            flag_op_s = 1'b1;
            res_s     = vy_r - vx_r;
            flag_s    = (vy_r >= vx_r);
          end
          4'hE: begin
            flag_op_s = 1'b1;
            res_s     = vx_r << 1;
            flag_s    = vx_r[DATA_W-1];
          end
          default: begin
            wr_vx_s   = 1'b0;
            illegal_s = 1'b1;
          end
        endcase
      end
      4'h9: begin
        if (instr_r[3:0] == 4'h0) begin
          skip_s = (vx_r != vy_r);
        end else begin
          illegal_s = 1'b1;
        end
      end
      4'hA: begin
        wr_i_s   = 1'b1;
        i_next_s = I_W'(instr_r[11:0]);
      end
      4'hF: begin
        if (instr_r[7:0] == 8'h1E) begin
          wr_i_s   = 1'b1;
          i_next_s = i_r + I_W'(vx_r);
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Sequencer: accept, operand latch, I update and registered completion outputs.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_r   <= ST_IDLE;
      instr_r   <= 16'h0000;
      vx_r      <= {DATA_W{1'b0}};
      vy_r      <= {DATA_W{1'b0}};
      flag_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      skip_r    <= 1'b0;
      illegal_r <= 1'b0;
      i_r       <= {I_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_r <= instr;
            ready_r <= 1'b0;
            state_r <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          vx_r    <= v_r[x_s];
          vy_r    <= v_r[y_s];
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          if (wr_i_s) begin
            i_r <= i_next_s;
          end
          flag_r <= flag_s;
          if (flag_op_s) begin
            state_r <= ST_FLAG;
          end else begin
            done_r    <= 1'b1;
            skip_r    <= skip_s;
            illegal_r <= illegal_s;
            state_r   <= ST_DONE;
          end
        end
        ST_FLAG: begin
          done_r    <= 1'b1;
          skip_r    <= skip_s;
          illegal_r <= illegal_s;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          done_r    <= 1'b0;
          skip_r    <= 1'b0;
          illegal_r <= 1'b0;
          ready_r   <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          done_r    <= 1'b0;
          skip_r    <= 1'b0;
          illegal_r <= 1'b0;
          ready_r   <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Register file: Vx written in EXEC, VF in FLAG so the flag wins when x is VF.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        v_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (state_r == ST_EXEC && wr_vx_s) begin
        v_r[x_s] <= res_s;
      end
      if (state_r == ST_FLAG) begin
        v_r[NUM_REGS-1] <= {{(DATA_W-1){1'b0}}, flag_r};
      end
    end
  end

endmodule

// File: tb/tb_chip8_exec_unit.sv
// Scoreboard bench for chip8_exec_unit: stimulus pushes expected completions,
// a negedge monitor pops and checks latency, skip and illegal at each done pulse.
module tb_chip8_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic        skip;
  logic        illegal;
  logic [15:0] i_reg;
  logic [3:0]  dbg_addr;
  logic [7:0]  dbg_data;

  typedef struct {
    int     acc;
    int     lat;
    logic   sk;
    logic   il;
    logic [15:0] op;
  } exp_t;

  exp_t sbq[$];
  int   cyc;
  int   checks;
  int   errors;

  chip8_exec_unit dut (
    .cpu_clk     (clk),
    .cpu_rst_n   (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .done        (done),
    .skip        (skip),
    .illegal     (illegal),
    .i_reg       (i_reg),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reg(input int idx, input logic [7:0] exp);
    dbg_addr = idx[3:0];
    #1;
    chk($sformatf("V%0h", idx), {24'h0, dbg_data}, {24'h0, exp});
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("latency_%04h", e.op), cyc + 1 - e.acc, e.lat);
          chk($sformatf("skip_%04h", e.op), {31'b0, skip}, {31'b0, e.sk});
          chk($sformatf("illegal_%04h", e.op), {31'b0, illegal}, {31'b0, e.il});
        end
      end else begin
        chk("quiet_flags", {30'b0, skip, illegal}, 32'd0);
      end
    end
  end

  // Offer op from a negedge, waiting (bounded) for ready; returns at the negedge after accept.
  task automatic send(input logic [15:0] op, input int lat, input logic sk,
                      input logic il, input bit push);
    int n;
    instr       = op;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_%04h", op), {31'b0, instr_ready}, 32'd1);
    if (push) begin
      exp_t e;
      e.acc = cyc + 1;
      e.lat = lat;
      e.sk  = sk;
      e.il  = il;
      e.op  = op;
      sbq.push_back(e);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int  n;
    bit  seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] op, input int lat, input logic sk, input logic il);
    send(op, lat, sk, il, 1'b1);
    wait_done();
  endtask

  initial begin
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    dbg_addr    = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_done", {29'b0, done, skip, illegal}, 32'd0);
    chk("rst_i", {16'h0, i_reg}, 32'd0);
    chk_reg(0, 8'h00);
    chk_reg(15, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load and add without flag
    run(16'h6A3C, 3, 1'b0, 1'b0);
    run(16'h7AF0, 3, 1'b0, 1'b0);
    chk_reg(10, 8'h2C);
    chk_reg(15, 8'h00);

    // Carry and borrow
    run(16'h61FF, 3, 1'b0, 1'b0);
    run(16'h6201, 3, 1'b0, 1'b0);
    run(16'h8124, 4, 1'b0, 1'b0);
    chk_reg(1, 8'h00);
    chk_reg(15, 8'h01);
    run(16'h8125, 4, 1'b0, 1'b0);
    chk_reg(1, 8'hFF);
    chk_reg(15, 8'h00);
    run(16'h8127, 4, 1'b0, 1'b0);
    chk_reg(1, 8'h02);
    chk_reg(15, 8'h00);
    run(16'h6105, 3, 1'b0, 1'b0);
    run(16'h8106, 4, 1'b0, 1'b0);
    chk_reg(1, 8'h02);
    chk_reg(15, 8'h01);
    run(16'h8213, 3, 1'b0, 1'b0);
    chk_reg(2, 8'h03);

    // Flag op targeting VF: flag overrides the shifted result
    run(16'h6F81, 3, 1'b0, 1'b0);
    run(16'h8F0E, 4, 1'b0, 1'b0);
    chk_reg(15, 8'h01);

    // Skips and illegal opcodes
    run(16'h6310, 3, 1'b0, 1'b0);
    run(16'h3310, 3, 1'b1, 1'b0);
    run(16'h4310, 3, 1'b0, 1'b0);
    run(16'h9320, 3, 1'b1, 1'b0);
    run(16'h5341, 3, 1'b0, 1'b1);
    run(16'h8328, 3, 1'b0, 1'b1);
    chk_reg(3, 8'h10);
    chk_reg(4, 8'h00);
    chk_reg(2, 8'h03);

    // I register, with the next op held valid while the unit is busy
    send(16'hA0FF, 3, 1'b0, 1'b0, 1'b1);
    send(16'h6003, 3, 1'b0, 1'b0, 1'b1);
    wait_done();
    chk("i_after_A0FF", {16'h0, i_reg}, 32'h00FF);
    run(16'hF01E, 3, 1'b0, 1'b0);
    chk("i_after_F01E", {16'h0, i_reg}, 32'h0102);

    // Reset during DECODE abandons the instruction
    send(16'h8124, 4, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, instr_ready}, 32'd1);
    chk("midrst_outs", {29'b0, done, skip, illegal}, 32'd0);
    chk("midrst_i", {16'h0, i_reg}, 32'd0);
    chk_reg(1, 8'h00);
    chk_reg(3, 8'h00);
    chk_reg(15, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_reg(1, 8'h00);
    chk_reg(15, 8'h00);
    chk("post_rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("queue_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
